// File: rtl/simd_arr_feeder.sv
// Sequential operand loader / result drainer wrapped around the combinational simd_arr datapath.
// Optional SIMD_ARR_FEEDER_PERF_EN adds completed-command and output-stall counters.
module simd_arr_feeder #(
  parameter int UNIT_SIZE = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [1:0]             i_cmd_op,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [UNIT_SIZE-1:0]   i_in_data,
  output logic [1:0]             o_arr_op,
  output logic [8*UNIT_SIZE-1:0] o_arr_in1,
  output logic [8*UNIT_SIZE-1:0] o_arr_in2,
  input  logic [8*UNIT_SIZE-1:0] i_arr_res,
  output logic                   o_out_valid,
  input  logic                   i_out_ready,
  output logic [UNIT_SIZE-1:0]   o_out_data,
  output logic                   o_out_last,
  output logic                   o_err,
  output logic [31:0]            o_perf_cmds,
  output logic [31:0]            o_perf_stall
);

  localparam int LANES = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  localparam logic [1:0] OP_MATMUL = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  logic [2:0]           state_r, state_s;
  logic [2:0]           cnt_r, cnt_s;
  logic [1:0]           op_r;
  logic [UNIT_SIZE-1:0] a_r   [LANES];
  logic [UNIT_SIZE-1:0] b_r   [LANES];
  logic [UNIT_SIZE-1:0] res_r [LANES];
  logic [UNIT_SIZE-1:0] arr_res_s [LANES];
  logic                 cmd_ready_r, in_ready_r, out_valid_r, err_r;
  logic                 cmd_hs_s, start_s, in_hs_s, out_hs_s;
  logic [2:0]           last_idx_s;

  // Lane 0 sits in the MSBs of every packed vector.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign o_arr_in1[(LANES-1-k)*UNIT_SIZE +: UNIT_SIZE] = a_r[k];
    assign o_arr_in2[(LANES-1-k)*UNIT_SIZE +: UNIT_SIZE] = b_r[k];
    assign arr_res_s[k] = i_arr_res[(LANES-1-k)*UNIT_SIZE +: UNIT_SIZE];
  end

  assign cmd_hs_s   = i_cmd_valid & cmd_ready_r;
  assign start_s    = cmd_hs_s & (i_cmd_op != OP_RSVD);
  assign in_hs_s    = i_in_valid & in_ready_r;
  assign out_hs_s   = out_valid_r & i_out_ready;
  assign last_idx_s = (op_r == OP_MATMUL) ? 3'd2 : 3'd7;

  assign o_cmd_ready = cmd_ready_r;
  assign o_in_ready  = in_ready_r;
  assign o_out_valid = out_valid_r;
  assign o_out_data  = res_r[cnt_r];
  assign o_out_last  = out_valid_r & (cnt_r == last_idx_s);
  assign o_err       = err_r;
  assign o_arr_op    = op_r;

  // Next-state and word-counter decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_s = ST_LOAD_A;
          cnt_s   = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD_A: begin
        if (in_hs_s && (cnt_r == 3'd7)) begin
          state_s = ST_LOAD_B;
          cnt_s   = 3'd0;
        end else if (in_hs_s) begin
          cnt_s = cnt_r + 3'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_LOAD_B: begin
        if (in_hs_s && (cnt_r == last_idx_s)) begin
          state_s = ST_EXEC;
          cnt_s   = 3'd0;
        end else if (in_hs_s) begin
          cnt_s = cnt_r + 3'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_EXEC: begin
        state_s = ST_DRAIN;
        cnt_s   = 3'd0;
      end
      ST_DRAIN: begin
        if (out_hs_s && (cnt_r == last_idx_s)) begin
          state_s = ST_IDLE;
          cnt_s   = 3'd0;
        end else if (out_hs_s) begin
          cnt_s = cnt_r + 3'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // State, counter and handshake flags; flags are registered from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      cmd_ready_r <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cmd_ready_r <= (state_s == ST_IDLE);
      in_ready_r  <= (state_s == ST_LOAD_A) || (state_s == ST_LOAD_B);
      out_valid_r <= (state_s == ST_DRAIN);
      err_r       <= cmd_hs_s & (i_cmd_op == OP_RSVD);
    end
  end

  // Opcode, operand and result registers; a new command wipes stale operand lanes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_r  <= 2'd0;
      a_r   <= '{default: '0};
      b_r   <= '{default: '0};
      res_r <= '{default: '0};
    end else begin
      if (start_s) begin
        op_r <= i_cmd_op;
        a_r  <= '{default: '0};
        b_r  <= '{default: '0};
      end else if (in_hs_s && (state_r == ST_LOAD_A)) begin
        a_r[cnt_r] <= i_in_data;
      end else if (in_hs_s && (state_r == ST_LOAD_B)) begin
        b_r[cnt_r] <= i_in_data;
      end else begin
        op_r <= op_r;
      end
      if (state_r == ST_EXEC) begin
        res_r <= arr_res_s;
      end else begin
        res_r <= res_r;
      end
    end
  end

`ifdef SIMD_ARR_FEEDER_PERF_EN
  logic [31:0] perf_cmds_r, perf_stall_r;

  // Completed-command and back-pressure counters, wrapping at 2^32.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      perf_cmds_r  <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (out_hs_s && o_out_last) begin
        perf_cmds_r <= perf_cmds_r + 32'd1;
      end else begin
        perf_cmds_r <= perf_cmds_r;
      end
      if (out_valid_r && !i_out_ready) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
    end
  end

  assign o_perf_cmds  = perf_cmds_r;
  assign o_perf_stall = perf_stall_r;
`else
  assign o_perf_cmds  = 32'd0;
  assign o_perf_stall = 32'd0;
`endif

endmodule

// File: tb/tb_simd_arr_feeder.sv
// Scoreboard bench for simd_arr_feeder: directed commands, expected words queued, checked by a monitor.
module tb_simd_arr_feeder;

  localparam int U = 32;

  logic           clk = 1'b0;
  logic           rst_n, cmd_valid, in_valid, out_ready;
  logic [1:0]     cmd_op;
  logic [U-1:0]   in_data;
  logic           cmd_ready, in_ready, out_valid, out_last, err;
  logic [1:0]     arr_op;
  logic [8*U-1:0] arr_in1, arr_in2, arr_res;
  logic [U-1:0]   out_data;
  logic [31:0]    perf_cmds, perf_stall;

  simd_arr_feeder #(.UNIT_SIZE(U)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_arr_op(arr_op), .o_arr_in1(arr_in1), .o_arr_in2(arr_in2), .i_arr_res(arr_res),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_out_last(out_last), .o_err(err),
    .o_perf_cmds(perf_cmds), .o_perf_stall(perf_stall)
  );

  always #5 clk = ~clk;

  // Stand-in array: ADD/SUB lane-wise, MATMUL stub = a + 1000*b so operand wiring is visible.
  always_comb begin
    logic [U-1:0] la, lb;
    arr_res = '0;
    for (int k = 0; k < 8; k++) begin
      la = arr_in1[(7-k)*U +: U];
      lb = arr_in2[(7-k)*U +: U];
      case (arr_op)
        2'd0:    arr_res[(7-k)*U +: U] = la + lb;
        2'd1:    arr_res[(7-k)*U +: U] = la - lb;
        2'd2:    arr_res[(7-k)*U +: U] = la + 32'd1000 * lb;
        default: arr_res[(7-k)*U +: U] = '0;
      endcase
    end
  end

  typedef struct packed { logic [U-1:0] data; logic last; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0, n_err = 0;
  int stalls = 0, done_cmds = 0;
  logic tog = 1'b0;
  logic [U-1:0] va [8], vb [8], ve [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each result handshake, checks stall stability.
  initial begin
    logic hold_pend;
    logic [U-1:0] hold_data;
    exp_t e;
    hold_pend = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (hold_pend && out_valid) chk("stall_hold", out_data, hold_data);
      hold_pend = 1'b0;
      if (out_valid && !out_ready) begin
        stalls++;
        hold_pend = 1'b1;
        hold_data = out_data;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_out: got %0h expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          if (e.last) done_cmds++;
        end
      end
    end
  end

  // Output ready driver: constant 1, or toggling when back-pressure is requested.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tog) out_ready = ~out_ready;
      else     out_ready = 1'b1;
    end
  end

  task automatic send_cmd(input logic [1:0] op);
    bit ok = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!ok) begin n_vec++; n_err++; $display("FAIL cmd_timeout: got no ready expected ready"); end
  endtask

  task automatic send_word(input logic [U-1:0] d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) begin n_vec++; n_err++; $display("FAIL in_timeout: got no ready expected ready"); end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_done", exp_q.size(), 0);
  endtask

  // Issues one command using va/vb, queues ve, and checks operands and EXEC latency.
  task automatic run_cmd(input logic [1:0] op, input int nb, input int ne);
    logic [8*U-1:0] x1, x2;
    x1 = '0;
    x2 = '0;
    for (int k = 0; k < 8; k++) x1[(7-k)*U +: U] = va[k];
    for (int k = 0; k < nb; k++) x2[(7-k)*U +: U] = vb[k];
    for (int k = 0; k < ne; k++) exp_q.push_back('{data: ve[k], last: (k == ne-1)});
    send_cmd(op);
    for (int k = 0; k < 8; k++) send_word(va[k]);
    for (int k = 0; k < nb; k++) send_word(vb[k]);
    @(negedge clk);
    chk("exec_no_valid", out_valid, 1'b0);
    chk("arr_op", arr_op, op);
    chk("arr_in1", arr_in1, x1);
    chk("arr_in2", arr_in2, x2);
    @(negedge clk);
    chk("first_valid", out_valid, 1'b1);
    wait_drain();
  endtask

  task automatic chk_perf();
`ifdef SIMD_ARR_FEEDER_PERF_EN
    chk("perf_cmds", perf_cmds, done_cmds);
    chk("perf_stall", perf_stall, stalls);
`else
    chk("perf_cmds_tied", perf_cmds, 32'd0);
    chk("perf_stall_tied", perf_stall, 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; in_valid = 1'b0; in_data = '0;

    // 1. Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_arr_op", arr_op, 2'd0);
    chk("rst_arr_in1", arr_in1, '0);
    chk("rst_arr_in2", arr_in2, '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_perf", {perf_cmds, perf_stall}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // 2. ADD
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'(k + 1); vb[k] = 32'(10 * (k + 1)); ve[k] = 32'(11 * (k + 1));
    end
    run_cmd(2'd0, 8, 8);

    // 3. SUB with toggling back-pressure
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'd100; vb[k] = 32'(k + 1); ve[k] = 32'(99 - k);
    end
    tog = 1'b1;
    run_cmd(2'd1, 8, 8);
    tog = 1'b0;
    chk_perf();

    // 4. MATMUL: B lanes 3..7 must read back as 0 despite the earlier commands
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'(k + 1); vb[k] = '0; ve[k] = '0;
    end
    vb[0] = 32'd2; vb[1] = 32'd3; vb[2] = 32'd4;
    ve[0] = 32'd2001; ve[1] = 32'd3002; ve[2] = 32'd4003;
    run_cmd(2'd2, 3, 3);

    // 5. Reserved op
    send_cmd(2'd3);
    @(negedge clk);
    chk("rsvd_err_pulse", err, 1'b1);
    chk("rsvd_in_ready", in_ready, 1'b0);
    @(negedge clk);
    chk("rsvd_err_clear", err, 1'b0);
    chk("rsvd_cmd_ready", cmd_ready, 1'b1);
    chk("rsvd_in_ready2", in_ready, 1'b0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'hFFFF_FFF0 + 32'(k); vb[k] = 32'd16; ve[k] = 32'(k);
    end
    run_cmd(2'd0, 8, 8);

    // 6. Reset in the middle of LOAD_A
    send_cmd(2'd0);
    for (int k = 0; k < 4; k++) send_word(32'(50 + k));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_in1", arr_in1, '0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    chk("mid_rst_perf", {perf_cmds, perf_stall}, 64'd0);
    done_cmds = 0;
    stalls = 0;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      va[k] = 32'(2 * (k + 1)); vb[k] = 32'd1; ve[k] = 32'(2 * (k + 1) + 1);
    end
    run_cmd(2'd0, 8, 8);
    chk_perf();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
